// File: rtl/cnter_pkg.sv
// Shared widths and the meter FSM state type for the cnter divider family.
package cnter_pkg;

  localparam int CNT_W   = 6;
  localparam int COUNT_W = 20;
  localparam int Q_W     = 7;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    DIVIDE,
    DONE
  } meter_state_t;

endpackage

// File: rtl/cnter_meter_if.sv
// Measurement-side signal bundle of cnter_meter: toggle input, control, result.
interface cnter_meter_if;
  import cnter_pkg::*;

  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] cnt_out;
  logic             valid;
  logic             err;
  logic             overflow;
  logic             overrun;

  modport master (
    output sig_in, enable,
    input  cnt_out, valid, err, overflow, overrun
  );

  modport slave (
    input  sig_in, enable,
    output cnt_out, valid, err, overflow, overrun
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous toggle plus a both-edge pulse.
module sync_edge_det (
  input  logic clockin,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 ^ s3;

endmodule

// File: rtl/cnter_meter.sv
// Measures the half-period of a toggle wave and recovers the cnter divider
// setting as a rounded multiple of DIVIDER, with error/overflow/overrun flags.
module cnter_meter
  import cnter_pkg::*;
#(
  parameter int DIVIDER    = 5000,
  parameter int TOL        = 2,
  parameter int COUNT_BITS = COUNT_W
) (
  input  logic          clockin,
  input  logic          reset_n,
  cnter_meter_if.slave  mif
);

  localparam logic [COUNT_BITS-1:0] DIV_C = COUNT_BITS'(DIVIDER);
  localparam logic [COUNT_BITS-1:0] TOL_C = COUNT_BITS'(TOL);
  localparam logic [COUNT_BITS-1:0] RND_C = COUNT_BITS'(DIVIDER - TOL);
  localparam logic [COUNT_BITS-1:0] CMAX  = '1;
  localparam logic [Q_W-1:0]        Q_LIM = Q_W'(64);
  localparam logic [Q_W-1:0]        Q_MAX = Q_W'(63);

  meter_state_t          state;
  logic                  edge_pulse;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] rem;
  logic [Q_W-1:0]        q;
  logic                  sat;

  logic                  round_up;
  logic [Q_W-1:0]        q_fin;
  logic [COUNT_BITS-1:0] r_fin;
  logic                  ovf_fin;

  sync_edge_det u_sync (
    .clockin    (clockin),
    .reset_n    (reset_n),
    .async_in   (mif.sig_in),
    .edge_pulse (edge_pulse)
  );

  // Edge-to-edge counter keeps running through DIVIDE/DONE so a period that
  // starts during an overrun is still measured correctly.
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (state == IDLE) begin
      count <= '0;
    end else if (edge_pulse) begin
      count <= '0;
    end else if (count != CMAX) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    round_up = (rem >= RND_C);
    q_fin    = round_up ? q + 1'b1 : q;
    r_fin    = round_up ? DIV_C - rem : rem;
    ovf_fin  = sat | (q_fin > Q_MAX);
  end

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rem      <= '0;
      q        <= '0;
      sat      <= 1'b0;
      mif.cnt_out  <= '0;
      mif.valid    <= 1'b0;
      mif.err      <= 1'b0;
      mif.overflow <= 1'b0;
      mif.overrun  <= 1'b0;
    end else begin
      mif.valid <= 1'b0;
      if (!mif.enable) begin
        state       <= IDLE;
        mif.overrun <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (edge_pulse) state <= MEASURE;
          end
          MEASURE: begin
            if (edge_pulse) begin
              rem   <= count;
              q     <= '0;
              sat   <= (count == CMAX);
              state <= DIVIDE;
            end
          end
          DIVIDE: begin
            if (edge_pulse) mif.overrun <= 1'b1;
            if (rem >= DIV_C && q < Q_LIM) begin
              rem <= rem - DIV_C;
              q   <= q + 1'b1;
            end else begin
              state <= DONE;
            end
          end
          DONE: begin
            if (edge_pulse) mif.overrun <= 1'b1;
            mif.err      <= (r_fin > TOL_C);
            mif.overflow <= ovf_fin;
            mif.cnt_out  <= ovf_fin ? '1 : q_fin[CNT_W-1:0];
            mif.valid    <= 1'b1;
            state        <= MEASURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnter_meter.sv
// Self-checking bench for cnter_meter: toggle periods from a vector table,
// random periods against an arithmetic model, and multi-cycle corner sequences.
module tb_cnter_meter;
  import cnter_pkg::*;

  localparam int D     = 10;
  localparam int TOLV  = 2;
  localparam int CB    = 12;
  localparam int CMAXV = (1 << CB) - 1;

  logic clockin = 1'b0;
  logic reset_n = 1'b0;

  cnter_meter_if bus ();

  cnter_meter #(
    .DIVIDER    (D),
    .TOL        (TOLV),
    .COUNT_BITS (CB)
  ) dut (
    .clockin (clockin),
    .reset_n (reset_n),
    .mif     (bus)
  );

  always #5 clockin = ~clockin;

  typedef struct {
    int t;
    int c;
    bit e;
    bit o;
  } res_t;

  typedef struct {
    int p;
    int c;
    bit e;
    bit o;
    int lat;
  } vec_t;

  int   ncyc = 0;
  int   last_t = 0;
  int   checks = 0;
  int   fails = 0;
  res_t rq[$];
  vec_t tbl[9];

  always @(negedge clockin) ncyc <= ncyc + 1;

  always @(negedge clockin)
    if (bus.valid === 1'b1)
      rq.push_back('{ncyc, int'(bus.cnt_out), bus.err, bus.overflow});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic toggle_after(input int p);
    int tgt;
    tgt = last_t + p;
    do @(negedge clockin); while (ncyc < tgt);
    if (ncyc != tgt) begin
      checks++;
      fails++;
      $display("FAIL toggle_timing: at cycle %0d expected cycle %0d", ncyc, tgt);
    end
    bus.sig_in = ~bus.sig_in;
    last_t = ncyc;
  endtask

  task automatic expect_res(input string tag, input int c, input bit e, input bit o,
                            input bit chk_err, input int lat);
    res_t r;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clockin);
      #1;
      if (rq.size() > 0) begin
        r  = rq.pop_front();
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: no valid within 100 cycles, expected cnt %0d", tag, c);
    end else begin
      chk({tag, "_cnt"}, r.c, c);
      chk({tag, "_ovf"}, r.o, o);
      if (chk_err) chk({tag, "_err"}, r.e, e);
      if (lat >= 0) chk({tag, "_lat"}, r.t - last_t, lat);
    end
  endtask

  // Expected result from half-period p: nearest multiple with the asymmetric
  // rounding window, plus latency measured from the sig_in toggle.
  function automatic void model(input int p, output int c, output bit e,
                                output bit o, output int lat);
    int rem, q, m, r;
    bit sat;
    rem = p - 1;
    sat = 1'b0;
    if (rem >= CMAXV) begin
      rem = CMAXV;
      sat = 1'b1;
    end
    q   = rem / D;
    m   = rem % D;
    lat = ((q > 64) ? 64 : q) + 5;
    if (m >= D - TOLV) begin
      q = q + 1;
      r = D - m;
    end else begin
      r = m;
    end
    o = sat || (q > 63);
    e = (r > TOLV);
    c = o ? 63 : q;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cnt_out"},  bus.cnt_out,  0);
    chk({tag, "_valid"},    bus.valid,    0);
    chk({tag, "_err"},      bus.err,      0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_overrun"},  bus.overrun,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  c, lat, p;
    bit  e, o;

    tbl[0] = '{31,   3, 1'b0, 1'b0, 8};
    tbl[1] = '{11,   1, 1'b0, 1'b0, 6};
    tbl[2] = '{71,   7, 1'b0, 1'b0, 12};
    tbl[3] = '{42,   4, 1'b0, 1'b0, 9};
    tbl[4] = '{49,   5, 1'b0, 1'b0, 9};
    tbl[5] = '{46,   4, 1'b1, 1'b0, 9};
    tbl[6] = '{631,  63, 1'b0, 1'b0, 68};
    tbl[7] = '{701,  63, 1'b0, 1'b1, 69};
    tbl[8] = '{5000, 63, 1'b0, 1'b1, 69};

    bus.sig_in = 1'b0;
    bus.enable = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clockin);
    chk_outputs_zero("reset");

    reset_n = 1'b1;
    @(negedge clockin);
    bus.enable = 1'b1;
    last_t = ncyc;
    toggle_after(10);

    foreach (tbl[i]) begin
      toggle_after(tbl[i].p);
      expect_res($sformatf("vec%0d", i), tbl[i].c, tbl[i].e, tbl[i].o, !tbl[i].o, tbl[i].lat);
    end

    for (int i = 0; i < 30; i++) begin
      p = int'($urandom_range(700, 70));
      model(p, c, e, o, lat);
      toggle_after(p);
      expect_res($sformatf("rnd%0d_p%0d", i, p), c, e, o, !o, lat);
    end

    // Edge 4 cycles into DIVIDE of a 60-cycle measurement.
    toggle_after(61);
    toggle_after(4);
    expect_res("overrun_inflight", 6, 1'b0, 1'b0, 1'b1, -1);
    chk("overrun_set", bus.overrun, 1);
    toggle_after(42);
    expect_res("after_overrun", 4, 1'b0, 1'b0, 1'b1, 9);
    chk("overrun_sticky", bus.overrun, 1);
    bus.enable = 1'b0;
    repeat (2) @(negedge clockin);
    chk("overrun_cleared", bus.overrun, 0);
    chk("hold_cnt_out", bus.cnt_out, 4);

    bus.enable = 1'b1;
    @(negedge clockin);
    last_t = ncyc;
    toggle_after(10);
    toggle_after(631);
    repeat (20) @(negedge clockin);
    bus.enable = 1'b0;
    repeat (100) @(negedge clockin);
    chk("disable_no_valid", rq.size(), 0);
    chk("disable_hold_cnt", bus.cnt_out, 4);
    chk("disable_hold_ovf", bus.overflow, 0);

    bus.enable = 1'b1;
    @(negedge clockin);
    last_t = ncyc;
    toggle_after(10);
    toggle_after(631);
    repeat (20) @(negedge clockin);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (3) @(negedge clockin);
    reset_n = 1'b1;
    repeat (100) @(negedge clockin);
    chk("midreset_no_valid", rq.size(), 0);
    chk("midreset_cnt_zero", bus.cnt_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
